whirlpool_work_ctrl: RTL and testbench

Nonce-scan controller that wraps the single-round-iterating Whirlpool core. It accepts one work unit (midstate, block template, target, nonce range) and inserts each nonce into the block. For each nonce it restarts the core and waits for its hash-ready pulse. It compares the result against the target and queues winning ("golden") nonces for the host-side work handler.

---
 rtl/whirlpool_work_ctrl_if.sv | 71 +++++++
 rtl/whirlpool_work_ctrl.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_whirlpool_work_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/whirlpool_work_ctrl_if.sv
// -----------------------------------------------------------------------------
// whirlpool_work_ctrl_if
//
// Purpose: groups the three handshakes of the Whirlpool nonce-scan controller
// into one bundle: the work-unit intake, the link to the single-round Whirlpool
// core, and the golden-nonce output queue.
//
// Modports:
//   master : environment side. It drives the work unit, the core result and
//            gold_ready. It observes work_ready, the core restart/inputs and
//            the golden nonce.
//   slave  : the controller (whirlpool_work_ctrl).
//
// Signals:
//   work_valid/work_ready       work-unit handshake (ready only when idle)
//   work_state     [511:0]      midstate
//   work_block     [511:0]      block template (nonce field is overwritten)
//   work_target    [63:0]       unsigned golden threshold
//   work_nonce_start/end [31:0] inclusive nonce range, may wrap through 0
//   work_abort                  abandon the current scan
//   core_rst                    one-cycle restart pulse to the core
//   core_state/core_block       core inputs, held stable while hashing
//   core_hash_ready/core_hash   core completion pulse and result
//   gold_valid/gold_ready       golden-nonce handshake
//   gold_nonce     [31:0]       head golden nonce
// -----------------------------------------------------------------------------
interface whirlpool_work_ctrl_if;

    // Work intake
    logic         work_valid;
    logic         work_ready;
    logic [511:0] work_state;
    logic [511:0] work_block;
    logic [63:0]  work_target;
    logic [31:0]  work_nonce_start;
    logic [31:0]  work_nonce_end;
    logic         work_abort;

    // Whirlpool core link
    logic         core_rst;
    logic [511:0] core_state;
    logic [511:0] core_block;
    logic         core_hash_ready;
    logic [511:0] core_hash;

    // Golden nonce output
    logic         gold_valid;
    logic         gold_ready;
    logic [31:0]  gold_nonce;

    modport master (
        output work_valid, work_state, work_block, work_target,
               work_nonce_start, work_nonce_end, work_abort,
        input  work_ready,
        input  core_rst, core_state, core_block,
        output core_hash_ready, core_hash,
        input  gold_valid, gold_nonce,
        output gold_ready
    );

    modport slave (
        input  work_valid, work_state, work_block, work_target,
               work_nonce_start, work_nonce_end, work_abort,
        output work_ready,
        output core_rst, core_state, core_block,
        input  core_hash_ready, core_hash,
        output gold_valid, gold_nonce,
        input  gold_ready
    );

endinterface

// File: rtl/whirlpool_work_ctrl.sv
// -----------------------------------------------------------------------------
// whirlpool_work_ctrl
//
// Purpose: nonce-scan controller wrapped around the single-round-iterating
// Whirlpool core. It accepts one work unit: midstate, block template, 64-bit
// target and an inclusive nonce range. For each nonce it inserts the nonce
// into the template and restarts the core. It then waits for the hash-ready
// pulse and compares hash[63:0] against the target. Nonces whose hash is at
// or below the target ("golden") are queued for the host.
//
// Parameters:
//   NONCE_LSB : bit offset of the 32-bit nonce field inside the 512-bit block
//   TIMEOUT   : HASH cycles to wait for core_hash_ready before relaunching
//
// Ports:
//   clk          system clock, all state on posedge
//   rst          synchronous active-high reset
//   bus          whirlpool_work_ctrl_if.slave (work / core / golden handshakes)
//   scan_done    one-cycle pulse when the range is exhausted or aborted
//   busy         high whenever the controller is not idle
//   timeout_err  sticky; set on the first core timeout, cleared by rst or by
//                accepted work
//
// Configuration macro:
//   WHIRLPOOL_GOLD_FIFO_EN : defined   -> golden store is a 4-entry FIFO
//                            undefined -> golden store is a single register
// -----------------------------------------------------------------------------
module whirlpool_work_ctrl #(
    parameter int NONCE_LSB = 0,
    parameter int TIMEOUT   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    whirlpool_work_ctrl_if.slave bus,
    output logic                 scan_done,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_HASH,
        S_CHECK
    } state_t;

    state_t state_q, state_d;

    // Latched work unit
    logic [511:0] mid_q;
    logic [511:0] tmpl_q;
    logic [63:0]  target_q;
    logic [31:0]  end_q;
    logic [31:0]  nonce_q;

    // Per-nonce working state
    logic [63:0]      h_q;
    logic [TMR_W-1:0] tmr_q;

    // Registered status outputs
    logic timeout_err_q;
    logic scan_done_q;
    logic work_ready_q;

    // Strobes decoded by the next-state logic, consumed by the datapath
    logic accept;      // work handshake taken this cycle
    logic capture_h;   // core result arrives this cycle
    logic timed_out;   // core missed its deadline, relaunch same nonce
    logic advance;     // step to the next nonce
    logic finish;      // leaving the scan for IDLE (range done or abort)
    logic push;        // golden nonce enters the store this cycle

    // Golden store status
    logic golden;
    logic store_full;
    logic pop;
    logic can_push;

    assign golden = (h_q <= target_q);
    assign pop    = bus.gold_valid && bus.gold_ready;
    // A pop on the same edge frees a slot, so a full store can still accept.
    assign can_push = !store_full || pop;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin : state_reg
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of process ordering.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and strobe decode
    // -------------------------------------------------------------------------
    always_comb begin : next_state
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would otherwise infer a latch.
        state_d   = state_q;
        accept    = 1'b0;
        capture_h = 1'b0;
        timed_out = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        push      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // work_ready_q is low for the first cycle after reset, so the
                // handshake is qualified on it rather than on the state alone.
                if (bus.work_valid && work_ready_q) begin
                    accept  = 1'b1;
                    state_d = S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                if (bus.work_abort) begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HASH;
                end
            end

            S_HASH: begin
                if (bus.work_abort) begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end else if (bus.core_hash_ready) begin
                    capture_h = 1'b1;
                    state_d   = S_CHECK;
                end else if (tmr_q == TMR_LAST) begin
                    timed_out = 1'b1;
                    state_d   = S_LAUNCH;
                end
            end

            S_CHECK: begin
                // A golden nonce with no room is held here, abort or not, so
                // no winning nonce is ever dropped.
                if (!(golden && !can_push)) begin
                    push = golden;
                    if (bus.work_abort || (nonce_q == end_q)) begin
                        finish  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        advance = 1'b1;
                        state_d = S_LAUNCH;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: work latches, nonce counter, timer, result and status
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin : datapath
        if (rst) begin
            mid_q         <= '0;
            tmpl_q        <= '0;
            target_q      <= '0;
            end_q         <= '0;
            nonce_q       <= '0;
            h_q           <= '0;
            tmr_q         <= '0;
            timeout_err_q <= 1'b0;
            scan_done_q   <= 1'b0;
            work_ready_q  <= 1'b0;
        end else begin
            work_ready_q <= (state_d == S_IDLE);
            scan_done_q  <= finish;

            if (accept) begin
                mid_q         <= bus.work_state;
                tmpl_q        <= bus.work_block;
                target_q      <= bus.work_target;
                end_q         <= bus.work_nonce_end;
                nonce_q       <= bus.work_nonce_start;
                timeout_err_q <= 1'b0;
            end else if (advance) begin
                // Wraps through 0xFFFFFFFF -> 0, so end < start is a valid range.
                nonce_q <= nonce_q + 32'd1;
            end

            if (timed_out) begin
                timeout_err_q <= 1'b1;
            end

            // The timer restarts on every launch, including timeout relaunches.
            if (state_q == S_LAUNCH) begin
                tmr_q <= '0;
            end else if (state_q == S_HASH) begin
                tmr_q <= tmr_q + TMR_W'(1);
            end

            if (capture_h) begin
                h_q <= bus.core_hash[63:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Core link and status outputs
    // -------------------------------------------------------------------------
    // core_block is built from registered template and nonce, so the nonce
    // field changes on the edge entering LAUNCH and is steady through HASH.
    always_comb begin : block_insert
        bus.core_block = tmpl_q;
        bus.core_block[NONCE_LSB +: 32] = nonce_q;
    end

    assign bus.core_state = mid_q;
    assign bus.core_rst   = (state_q == S_LAUNCH);
    assign bus.work_ready = work_ready_q;
    assign busy           = (state_q != S_IDLE);
    assign scan_done      = scan_done_q;
    assign timeout_err    = timeout_err_q;

    // -------------------------------------------------------------------------
    // Golden store
    // -------------------------------------------------------------------------
`ifdef WHIRLPOOL_GOLD_FIFO_EN
    logic [31:0] fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  fifo_cnt;

    always_ff @(posedge clk) begin : fifo_ctrl
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // NOTE: storage words carry no reset; emptiness is tracked by the pointers
    // and count, and the output is masked while empty.
    always_ff @(posedge clk) begin : fifo_store
        if (push) begin
            fifo_mem[wr_ptr] <= nonce_q;
        end
    end

    // When full, wr_ptr == rd_ptr: a simultaneous push/pop overwrites the
    // head slot after it has been read out on this same edge.
    assign store_full     = (fifo_cnt == 3'd4);
    assign bus.gold_valid = (fifo_cnt != 3'd0);
    assign bus.gold_nonce = bus.gold_valid ? fifo_mem[rd_ptr] : 32'd0;
`else
    logic [31:0] gold_q;
    logic        gold_valid_q;

    always_ff @(posedge clk) begin : gold_reg
        if (rst) begin
            gold_q       <= '0;
            gold_valid_q <= 1'b0;
        end else if (push) begin
            gold_q       <= nonce_q;
            gold_valid_q <= 1'b1;
        end else if (pop) begin
            gold_valid_q <= 1'b0;
        end
    end

    assign store_full     = gold_valid_q;
    assign bus.gold_valid = gold_valid_q;
    assign bus.gold_nonce = gold_q;
`endif

    // Only the low 64 bits of the core result are compared against the target.
    logic unused_hash_bits;
    assign unused_hash_bits = ^bus.core_hash[511:64];

endmodule

// File: tb/tb_whirlpool_work_ctrl.sv
// -----------------------------------------------------------------------------
// tb_whirlpool_work_ctrl
//
// Self-checking bench for whirlpool_work_ctrl. A behavioural core model
// answers each core_rst after a programmable latency. The hash it returns is
// a fixed function of the nonce read from core_block. A consumer drives
// gold_ready (random, always-on or held off). The expected nonce sequence and
// golden list of a scan come from walking the range with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_whirlpool_work_ctrl;

    localparam int NONCE_LSB = 96;
`ifdef WHIRLPOOL_GOLD_FIFO_EN
    localparam int GOLD_DEPTH = 4;
`else
    localparam int GOLD_DEPTH = 1;
`endif
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    logic scan_done;
    logic busy;
    logic timeout_err;

    whirlpool_work_ctrl_if bus ();

    whirlpool_work_ctrl #(
        .NONCE_LSB(NONCE_LSB),
        .TIMEOUT  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .scan_done  (scan_done),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- environment
    int          lat        = 20;     // core_rst cycle to hash_ready cycle
    bit          withhold   = 1'b0;   // core never answers
    int          gold_mode  = 1;      // 0 random, 1 always ready, 2 never ready
    logic [31:0] zero_nonce = 32'hDEAD_BEEF;
    logic [31:0] rst_seen[$];
    logic [31:0] gold_seen[$];
    int          done_cnt   = 0;

    function automatic logic [63:0] hfun(input logic [31:0] n);
        if (n == zero_nonce) return 64'h0;
        return {n * 32'h9E37_79B1, n ^ 32'h5A5A_1234} | 64'h1;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    initial begin : env
        int          cnt = -1;
        logic [31:0] cur_nonce = '0;
        bit          prev_hold = 1'b0;
        logic [31:0] prev_nonce = '0;
        bus.core_hash_ready = 1'b0;
        bus.core_hash       = '0;
        bus.gold_ready      = 1'b0;
        forever begin
            @(negedge clk);
            // Golden consumer
            if (prev_hold && !rst) begin
                check("gold_hold_valid", 64'(bus.gold_valid), 64'(1));
                check("gold_hold_nonce", 64'(bus.gold_nonce), 64'(prev_nonce));
            end
            case (gold_mode)
                0:       bus.gold_ready = 1'($urandom_range(0, 1));
                1:       bus.gold_ready = 1'b1;
                default: bus.gold_ready = 1'b0;
            endcase
            if (bus.gold_valid && bus.gold_ready && !rst) gold_seen.push_back(bus.gold_nonce);
            prev_hold  = bus.gold_valid && !bus.gold_ready && !rst;
            prev_nonce = bus.gold_nonce;
            if (scan_done) done_cnt++;
            // Core model
            bus.core_hash_ready = 1'b0;
            bus.core_hash       = rand512();
            if (bus.core_rst) begin
                cur_nonce = bus.core_block[NONCE_LSB +: 32];
                rst_seen.push_back(cur_nonce);
                cnt = lat;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    if (!withhold) begin
                        bus.core_hash_ready  = 1'b1;
                        bus.core_hash[63:0]  = hfun(cur_nonce);
                    end
                    cnt = -1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic do_reset();
        rst = 1'b1;
        bus.work_valid = 1'b0;
        bus.work_abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_core_rst",    64'(bus.core_rst),    64'(0));
        check("rst_busy",        64'(busy),            64'(0));
        check("rst_work_ready",  64'(bus.work_ready),  64'(0));
        check("rst_gold_valid",  64'(bus.gold_valid),  64'(0));
        check("rst_gold_nonce",  64'(bus.gold_nonce),  64'(0));
        check("rst_scan_done",   64'(scan_done),       64'(0));
        check("rst_timeout_err", 64'(timeout_err),     64'(0));
        check("rst_core_block",  bus.core_block[NONCE_LSB +: 64], 64'(0));
        check("rst_core_state",  bus.core_state[63:0], 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", 64'(bus.work_ready), 64'(1));
        rst_seen.delete();
        gold_seen.delete();
        done_cnt = 0;
    endtask

    // Returns at the first negedge after the handshake edge.
    task automatic start_work(input logic [31:0] s, input logic [31:0] e, input logic [63:0] t,
                              output logic [511:0] mid, output logic [511:0] blk);
        int n = 0;
        while (!bus.work_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("work_ready_before_hs", 64'(bus.work_ready), 64'(1));
        rst_seen.delete();
        gold_seen.delete();
        done_cnt = 0;
        mid = rand512();
        blk = rand512();
        bus.work_state       = mid;
        bus.work_block       = blk;
        bus.work_target      = t;
        bus.work_nonce_start = s;
        bus.work_nonce_end   = e;
        bus.work_valid       = 1'b1;
        @(negedge clk);
        bus.work_valid       = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!scan_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("scan_done_seen", 64'(scan_done), 64'(1));
    endtask

    task automatic drain();
        int n = 0;
        gold_mode = 1;
        while (bus.gold_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("gold_drained", 64'(bus.gold_valid), 64'(0));
    endtask

    // Reference: walk start..end (mod 2^32) and filter by hash <= target.
    task automatic expect_scan(input logic [31:0] s, input logic [31:0] e, input logic [63:0] t);
        logic [31:0] exp_n[$];
        logic [31:0] exp_g[$];
        logic [31:0] n = s;
        for (int k = 0; k < 64; k++) begin
            exp_n.push_back(n);
            if (hfun(n) <= t) exp_g.push_back(n);
            if (n == e) break;
            n = n + 32'd1;
        end
        check("scan_rst_count", 64'(rst_seen.size()), 64'(exp_n.size()));
        for (int i = 0; i < exp_n.size() && i < rst_seen.size(); i++)
            check($sformatf("scan_nonce[%0d]", i), 64'(rst_seen[i]), 64'(exp_n[i]));
        check("scan_gold_count", 64'(gold_seen.size()), 64'(exp_g.size()));
        for (int i = 0; i < exp_g.size() && i < gold_seen.size(); i++)
            check($sformatf("scan_gold[%0d]", i), 64'(gold_seen[i]), 64'(exp_g[i]));
        check("scan_done_count", 64'(done_cnt), 64'(1));
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------------------------------------------------------- tests
    initial begin : main
        logic [511:0] mid, blk, exp_blk;
        int           n;
        rst                  = 1'b1;
        bus.work_valid       = 1'b0;
        bus.work_abort       = 1'b0;
        bus.work_state       = '0;
        bus.work_block       = '0;
        bus.work_target      = '0;
        bus.work_nonce_start = '0;
        bus.work_nonce_end   = '0;
        do_reset();

        // Single nonce, all golden, held golden output
        gold_mode = 2;
        start_work(32'h5, 32'h5, ALL_ONES, mid, blk);
        check("single_core_rst", 64'(bus.core_rst), 64'(1));
        check("single_nonce_field", 64'(bus.core_block[NONCE_LSB +: 32]), 64'(5));
        wait_done(200, n);
        check("single_latency", 64'(n), 64'(22));
        check("single_gold_valid", 64'(bus.gold_valid), 64'(1));
        check("single_gold_nonce", 64'(bus.gold_nonce), 64'(5));
        exp_blk = blk;
        exp_blk[NONCE_LSB +: 32] = 32'h5;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("single_core_block[%0d]", i), bus.core_block[i*64 +: 64], exp_blk[i*64 +: 64]);
            check($sformatf("single_core_state[%0d]", i), bus.core_state[i*64 +: 64], mid[i*64 +: 64]);
        end
        drain();
        expect_scan(32'h5, 32'h5, ALL_ONES);

        // Range with exactly one H == 0 nonce, target 0
        zero_nonce = 32'h12;
        gold_mode  = 0;
        start_work(32'h10, 32'h13, 64'h0, mid, blk);
        wait_done(400, n);
        drain();
        expect_scan(32'h10, 32'h13, 64'h0);
        zero_nonce = 32'hDEAD_BEEF;

        // Wrap through 0xFFFFFFFF -> 0
        gold_mode = 1;
        start_work(32'hFFFF_FFFE, 32'h1, ALL_ONES, mid, blk);
        wait_done(400, n);
        drain();
        expect_scan(32'hFFFF_FFFE, 32'h1, ALL_ONES);

        // Backpressure: six golden nonces, consumer held off
        gold_mode = 2;
        start_work(32'h40, 32'h45, ALL_ONES, mid, blk);
        repeat ((GOLD_DEPTH + 2) * 22 + 20) @(negedge clk);
        check("bp_rst_count", 64'(rst_seen.size()), 64'(GOLD_DEPTH + 1));
        check("bp_busy", 64'(busy), 64'(1));
        check("bp_gold_valid", 64'(bus.gold_valid), 64'(1));
        check("bp_gold_head", 64'(bus.gold_nonce), 64'(32'h40));
        check("bp_no_pops", 64'(gold_seen.size()), 64'(0));
        gold_mode = 1;
        wait_done(600, n);
        drain();
        expect_scan(32'h40, 32'h45, ALL_ONES);

        // Timeout: core silent, relaunch with same nonce, sticky error
        withhold  = 1'b1;
        gold_mode = 1;
        start_work(32'h7, 32'h7, ALL_ONES, mid, blk);
        n = 0;
        while (!timeout_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", 64'(n), 64'(33));
        check("timeout_relaunch", 64'(bus.core_rst), 64'(1));
        check("timeout_nonce", 64'(bus.core_block[NONCE_LSB +: 32]), 64'(7));
        withhold = 1'b0;
        @(negedge clk);
        check("timeout_rst_count", 64'(rst_seen.size()), 64'(2));
        wait_done(200, n);
        check("timeout_sticky", 64'(timeout_err), 64'(1));
        drain();
        start_work(32'h9, 32'h9, ALL_ONES, mid, blk);
        check("timeout_cleared", 64'(timeout_err), 64'(0));
        wait_done(200, n);
        drain();
        expect_scan(32'h9, 32'h9, ALL_ONES);

        // Abort in HASH of the second nonce; first golden nonce preserved
        gold_mode = 2;
        start_work(32'h200, 32'h2FF, ALL_ONES, mid, blk);
        repeat (30) @(negedge clk);
        check("abort_in_hash_busy", 64'(busy), 64'(1));
        bus.work_abort = 1'b1;
        @(negedge clk);
        bus.work_abort = 1'b0;
        check("abort_idle", 64'(busy), 64'(0));
        check("abort_scan_done", 64'(scan_done), 64'(1));
        check("abort_work_ready", 64'(bus.work_ready), 64'(1));
        check("abort_gold_valid", 64'(bus.gold_valid), 64'(1));
        check("abort_gold_nonce", 64'(bus.gold_nonce), 64'(32'h200));
        drain();
        check("abort_gold_count", 64'(gold_seen.size()), 64'(1));

        // Reset mid-scan with a golden nonce held
        gold_mode = 2;
        start_work(32'h300, 32'h3FF, ALL_ONES, mid, blk);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_gold_valid", 64'(bus.gold_valid), 64'(0));
        check("midrst_work_ready", 64'(bus.work_ready), 64'(0));
        check("midrst_scan_done", 64'(scan_done), 64'(0));
        do_reset();

        // Randomized scans, some straddling the wrap
        for (int it = 0; it < 10; it++) begin
            logic [31:0] s, e;
            logic [63:0] t;
            int          len;
            s   = (it % 3 == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom();
            len = $urandom_range(1, 6);
            e   = s + 32'(len - 1);
            t   = {$urandom(), $urandom()};
            lat = $urandom_range(1, 25);
            gold_mode = 0;
            start_work(s, e, t, mid, blk);
            wait_done(2000, n);
            drain();
            expect_scan(s, e, t);
        end
        lat = 20;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
